// File: rtl/riscv_dmem_if.sv
// Data-memory interface between the core load/store unit and a single-outstanding bus.
// Aligns byte/half/word requests onto word-wide bus cycles and returns one response pulse per access.
module riscv_dmem_if #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 256
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_req_i,
    output logic            mem_ready_o,
    input  logic [XLEN-1:0] mem_adr_i,
    input  logic            mem_we_i,
    input  logic [2:0]      mem_size_i,
    input  logic [XLEN-1:0] mem_d_i,
    input  logic            flush_i,
    output logic            dmem_ack_o,
    output logic            dmem_err_o,
    output logic            dmem_misaligned_o,
    output logic            dmem_page_fault_o,
    output logic [XLEN-1:0] dmem_q_o,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    output logic [XLEN-1:0] biu_adr_o,
    output logic            biu_we_o,
    output logic [3:0]      biu_be_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_ack_i,
    input  logic            biu_err_i,
    input  logic [XLEN-1:0] biu_q_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int         WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit         WD_EN   = (TIMEOUT != 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    // Handshake: the core holds mem_req_i with stable fields until a cycle where
    // mem_ready_o is also high; that cycle is the acceptance. On the bus side
    // biu_stb_o is held with stable address/control until biu_stb_ack_i.
    logic [1:0]      r_state;
    logic            r_stb;
    logic [XLEN-1:0] r_adr;
    logic            r_we;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_d;
    logic            r_ack;
    logic            r_err;
    logic            r_mis;
    logic [XLEN-1:0] r_q;
    logic [WDW-1:0]  r_wd;

    logic            w_accept;
    logic            w_illegal;
    logic            w_misaligned;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_d;
    logic            w_done;

    assign mem_ready_o = (r_state == IDLE) && !flush_i;
    assign w_accept    = mem_req_i && mem_ready_o;
    assign w_done      = biu_ack_i || biu_err_i;

    always_comb begin
        w_illegal = 1'b1;
        case (mem_size_i)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
            default:                                w_illegal = 1'b1;
        endcase
    end

    assign w_misaligned = ((mem_size_i[1:0] == 2'b01) && mem_adr_i[0]) ||
                          ((mem_size_i[1:0] == 2'b10) && (mem_adr_i[1:0] != 2'b00));

    // Lane steering: byte and half data are replicated so every enabled lane sees it.
    always_comb begin
        w_be = 4'b1111;
        w_d  = mem_d_i;
        case (mem_size_i[1:0])
            2'b00: begin
                w_be = 4'b0001 << mem_adr_i[1:0];
                w_d  = {4{mem_d_i[7:0]}};
            end
            2'b01: begin
                w_be = 4'b0011 << mem_adr_i[1:0];
                w_d  = {2{mem_d_i[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_d  = mem_d_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_stb   <= 1'b0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_d     <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_mis   <= 1'b0;
            r_q     <= '0;
            r_wd    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_mis <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else if (w_misaligned) begin
                            r_mis <= 1'b1;
                        end else begin
                            r_state <= REQ;
                            r_stb   <= 1'b1;
                            r_adr   <= {mem_adr_i[XLEN-1:2], 2'b00};
                            r_we    <= mem_we_i;
                            r_be    <= w_be;
                            r_d     <= w_d;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        r_stb <= 1'b0;
                        if (biu_stb_ack_i && !w_done) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (biu_stb_ack_i) begin
                        r_stb <= 1'b0;
                        if (w_done) begin
                            r_state <= IDLE;
                            r_err   <= biu_err_i;
                            r_ack   <= !biu_err_i;
                            if (!r_we && !biu_err_i) r_q <= biu_q_i;
                        end else begin
                            r_state <= WAIT;
                            r_wd    <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (flush_i) begin
                        r_state <= w_done ? IDLE : DRAIN;
                    end else if (w_done) begin
                        r_state <= IDLE;
                        r_err   <= biu_err_i;
                        r_ack   <= !biu_err_i;
                        if (!r_we && !biu_err_i) r_q <= biu_q_i;
                    end else if (WD_EN && (r_wd == WD_LAST)) begin
                        // The bus may still answer later; DRAIN absorbs that stale completion.
                        r_err   <= 1'b1;
                        r_state <= DRAIN;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                default: begin
                    if (w_done) r_state <= IDLE;
                end
            endcase
        end
    end

    assign dmem_ack_o        = r_ack;
    assign dmem_err_o        = r_err;
    assign dmem_misaligned_o = r_mis;
    assign dmem_page_fault_o = 1'b0;
    assign dmem_q_o          = r_q;
    assign biu_stb_o         = r_stb;
    assign biu_adr_o         = r_adr;
    assign biu_we_o          = r_we;
    assign biu_be_o          = r_be;
    assign biu_d_o           = r_d;

endmodule

// File: tb/tb_riscv_dmem_if.sv
// Directed bench for riscv_dmem_if: drivers push expected responses into a queue,
// a negedge monitor pops and compares every response pulse the DUT produces.
module tb_riscv_dmem_if;
  localparam int XLEN = 32;
  localparam logic [1:0] K_ACK = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;
  localparam logic [1:0] K_MIS = 2'd3;
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            mem_req_i = 1'b0;
  logic            mem_ready_o;
  logic [XLEN-1:0] mem_adr_i = '0;
  logic            mem_we_i = 1'b0;
  logic [2:0]      mem_size_i = 3'b000;
  logic [XLEN-1:0] mem_d_i = '0;
  logic            flush_i = 1'b0;
  logic            dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_page_fault_o;
  logic [XLEN-1:0] dmem_q_o;
  logic            biu_stb_o;
  logic            biu_stb_ack_i = 1'b0;
  logic [XLEN-1:0] biu_adr_o;
  logic            biu_we_o;
  logic [3:0]      biu_be_o;
  logic [XLEN-1:0] biu_d_o;
  logic            biu_ack_i = 1'b0;
  logic            biu_err_i = 1'b0;
  logic [XLEN-1:0] biu_q_i = '0;

  riscv_dmem_if #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_ready_o(mem_ready_o), .mem_adr_i(mem_adr_i),
    .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_d_i(mem_d_i), .flush_i(flush_i),
    .dmem_ack_o(dmem_ack_o), .dmem_err_o(dmem_err_o), .dmem_misaligned_o(dmem_misaligned_o),
    .dmem_page_fault_o(dmem_page_fault_o), .dmem_q_o(dmem_q_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_adr_o(biu_adr_o),
    .biu_we_o(biu_we_o), .biu_be_o(biu_be_o), .biu_d_o(biu_d_o),
    .biu_ack_i(biu_ack_i), .biu_err_i(biu_err_i), .biu_q_i(biu_q_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [XLEN+1:0] exp_q[$];
  logic [XLEN-1:0] model_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin : monitor
    int n;
    logic [1:0] kind;
    logic [XLEN+1:0] e;
    if (rst_ni && (dmem_ack_o || dmem_err_o || dmem_misaligned_o)) begin
      n = int'(dmem_ack_o) + int'(dmem_err_o) + int'(dmem_misaligned_o);
      check("resp_onehot", 32'(n), 32'd1);
      kind = dmem_ack_o ? K_ACK : (dmem_err_o ? K_ERR : K_MIS);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got kind %0d expected none", kind);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", 32'(kind), 32'(e[XLEN+1:XLEN]));
        if (e[XLEN+1:XLEN] == K_ACK) check("resp_q", dmem_q_o, e[XLEN-1:0]);
      end
    end
  end

  // driver tasks
  task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] adr,
                       input logic [31:0] d);
    int n = 0;
    @(negedge clk_i);
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_adr_i = adr; mem_d_i = d;
    #1;
    while (!mem_ready_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!mem_ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
      mem_req_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1;
      mem_req_i = 1'b0;
    end
  endtask

  task automatic wait_stb();
    int n = 0;
    @(negedge clk_i);
    while (!biu_stb_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("stb_seen", 32'(biu_stb_o), 32'd1);
  endtask

  task automatic bus_cycle(input logic [31:0] e_adr, input logic [3:0] e_be,
                           input logic [31:0] e_d, input logic e_we, input int gap,
                           input logic ack, input logic err, input logic [31:0] q);
    wait_stb();
    check("biu_adr", biu_adr_o, e_adr);
    check("biu_be", 32'(biu_be_o), 32'(e_be));
    check("biu_d", biu_d_o, e_d);
    check("biu_we", 32'(biu_we_o), 32'(e_we));
    biu_stb_ack_i = 1'b1;
    if (gap == 0) begin
      biu_ack_i = ack; biu_err_i = err; biu_q_i = q;
    end
    @(negedge clk_i);
    biu_stb_ack_i = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) @(negedge clk_i);
      biu_ack_i = ack; biu_err_i = err; biu_q_i = q;
      @(negedge clk_i);
    end
    biu_ack_i = 1'b0;
    biu_err_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] q);
    exp_q.push_back({kind, q});
  endtask

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk_i);
    check("rst_stb", 32'(biu_stb_o), 32'd0);
    check("rst_we", 32'(biu_we_o), 32'd0);
    check("rst_be", 32'(biu_be_o), 32'd0);
    check("rst_adr", biu_adr_o, 32'd0);
    check("rst_d", biu_d_o, 32'd0);
    check("rst_q", dmem_q_o, 32'd0);
    check("rst_resp", {29'd0, dmem_ack_o, dmem_err_o, dmem_misaligned_o}, 32'd0);
    check("rst_pf", 32'(dmem_page_fault_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    check("rst_ready", 32'(mem_ready_o), 32'd1);

    // load word: stb_ack cycle 1, ack cycle 3, pulse cycle 4
    model_q = 32'hDEADBEEF;
    push(K_ACK, model_q);
    issue(1'b0, SZ_W, 32'h0000_1000, 32'h0);
    bus_cycle(32'h1000, 4'b1111, 32'h0, 1'b0, 2, 1'b1, 1'b0, 32'hDEADBEEF);
    check("lw_pulse_c4", 32'(dmem_ack_o), 32'd1);
    @(negedge clk_i);
    check("lw_pulse_single", 32'(dmem_ack_o), 32'd0);

    // store byte, upper lane; q must stay
    push(K_ACK, model_q);
    issue(1'b1, SZ_B, 32'h0000_1003, 32'h0000_00A5);
    bus_cycle(32'h1000, 4'b1000, 32'hA5A5A5A5, 1'b1, 1, 1'b1, 1'b0, 32'h0BAD_0BAD);

    push(K_ACK, model_q);
    issue(1'b1, SZ_H, 32'h0000_2002, 32'hFFFF_BEEF);
    bus_cycle(32'h2000, 4'b1100, 32'hBEEFBEEF, 1'b1, 0, 1'b1, 1'b0, 32'h0);

    model_q = 32'h0000_AB00;
    push(K_ACK, model_q);
    issue(1'b0, SZ_BU, 32'h0000_1001, 32'h0);
    bus_cycle(32'h1000, 4'b0010, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_AB00);

    model_q = 32'hCAFE_0000;
    push(K_ACK, model_q);
    issue(1'b0, SZ_HU, 32'h0000_2002, 32'h0000_1234);
    bus_cycle(32'h2000, 4'b1100, 32'h12341234, 1'b0, 0, 1'b1, 1'b0, 32'hCAFE_0000);

    push(K_ACK, model_q);
    issue(1'b1, SZ_W, 32'h0000_4000, 32'h1122_3344);
    bus_cycle(32'h4000, 4'b1111, 32'h11223344, 1'b1, 3, 1'b1, 1'b0, 32'h0);

    // misaligned / illegal: no bus cycle, pulse in the next cycle
    push(K_MIS, 32'h0);
    issue(1'b0, SZ_H, 32'h0000_2001, 32'h0);
    check("mis_h_pulse", 32'(dmem_misaligned_o), 32'd1);
    check("mis_h_nostb", 32'(biu_stb_o), 32'd0);
    push(K_MIS, 32'h0);
    issue(1'b1, SZ_W, 32'h0000_4002, 32'h0);
    check("mis_w_pulse", 32'(dmem_misaligned_o), 32'd1);
    push(K_ERR, 32'h0);
    issue(1'b0, 3'b011, 32'h0000_2000, 32'h0);
    check("ill_pulse", 32'(dmem_err_o), 32'd1);
    check("ill_nostb", 32'(biu_stb_o), 32'd0);
    push(K_ERR, 32'h0);
    issue(1'b0, 3'b111, 32'h0000_2001, 32'h0);
    check("ill_over_mis", 32'(dmem_err_o), 32'd1);
    @(negedge clk_i);
    check("ill_nostb_later", 32'(biu_stb_o), 32'd0);

    // ack and err together: only err
    push(K_ERR, 32'h0);
    issue(1'b0, SZ_W, 32'h0000_5000, 32'h0);
    bus_cycle(32'h5000, 4'b1111, 32'h0, 1'b0, 2, 1'b1, 1'b1, 32'h5555_5555);

    model_q = 32'h0000_0606;
    push(K_ACK, model_q);
    issue(1'b0, SZ_W, 32'h0000_5004, 32'h0);
    bus_cycle(32'h5004, 4'b1111, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_0606);

    // watchdog: TIMEOUT=4, err after 4 WAIT cycles, late ack discarded
    push(K_ERR, 32'h0);
    issue(1'b0, SZ_W, 32'h0000_6000, 32'h0);
    wait_stb();
    biu_stb_ack_i = 1'b1;
    @(negedge clk_i);
    biu_stb_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("wd_not_early", 32'(dmem_err_o), 32'd0);
    @(negedge clk_i);
    check("wd_err", 32'(dmem_err_o), 32'd1);
    repeat (2) @(negedge clk_i);
    check("wd_drain_busy", 32'(mem_ready_o), 32'd0);
    biu_ack_i = 1'b1;
    biu_q_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    biu_ack_i = 1'b0;
    #1;
    check("wd_drain_done", 32'(mem_ready_o), 32'd1);
    model_q = 32'h0000_0077;
    push(K_ACK, model_q);
    issue(1'b0, SZ_W, 32'h0000_7000, 32'h0);
    bus_cycle(32'h7000, 4'b1111, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_0077);

    // flush in WAIT, ack two cycles later: no response
    issue(1'b0, SZ_W, 32'h0000_8000, 32'h0);
    wait_stb();
    biu_stb_ack_i = 1'b1;
    @(negedge clk_i);
    biu_stb_ack_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("flw_ready_c3", 32'(mem_ready_o), 32'd0);
    @(negedge clk_i);
    biu_ack_i = 1'b1;
    #1;
    check("flw_ready_c4", 32'(mem_ready_o), 32'd0);
    @(negedge clk_i);
    biu_ack_i = 1'b0;
    #1;
    check("flw_ready_after", 32'(mem_ready_o), 32'd1);

    // flush in REQ without stb_ack: strobe withdrawn
    issue(1'b1, SZ_W, 32'h0000_9000, 32'h0);
    wait_stb();
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("flr_stb_drop", 32'(biu_stb_o), 32'd0);
    check("flr_ready", 32'(mem_ready_o), 32'd1);

    // flush arriving in the pulse cycle does not cancel the pulse
    model_q = 32'h0000_1111;
    push(K_ACK, model_q);
    issue(1'b0, SZ_W, 32'h0000_A000, 32'h0);
    bus_cycle(32'hA000, 4'b1111, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_1111);
    flush_i = 1'b1;
    #1;
    check("fl_pulse_kept", 32'(dmem_ack_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0;

    // reset mid-access: stb drops at once, nothing delivered after release
    issue(1'b0, SZ_W, 32'h0000_B000, 32'h0);
    wait_stb();
    rst_ni = 1'b0;
    #1;
    check("rst_mid_stb", 32'(biu_stb_o), 32'd0);
    biu_stb_ack_i = 1'b1;
    biu_ack_i = 1'b1;
    @(negedge clk_i);
    biu_stb_ack_i = 1'b0;
    biu_ack_i = 1'b0;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_mid_q", dmem_q_o, 32'd0);
    model_q = 32'h0000_5A5A;
    push(K_ACK, model_q);
    issue(1'b0, SZ_W, 32'h0000_C000, 32'h0);
    bus_cycle(32'hC000, 4'b1111, 32'h0, 1'b0, 1, 1'b1, 1'b0, 32'h0000_5A5A);

    repeat (4) @(negedge clk_i);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
